// File: rtl/seq_step_monitor.sv
// rtl/seq_step_monitor.sv - step checker for the 3-bit state counter (optional SEQ_MON_STALL_EN accepts repeated samples as holds)
module seq_step_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [2:0]       cnt_in,
  input  logic             cnt_vld,
  input  logic             clr,
  output logic [7:0]       onehot_out,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err,
  output logic [1:0]       state_o
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_TRACK = 2'b01;
  localparam logic [1:0] ST_FAULT = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [2:0]       prev_q, prev_d;
  logic [7:0]       onehot_q, onehot_d;
  logic [CNT_W-1:0] wrap_q, wrap_d;
  logic [CNT_W-1:0] errc_q, errc_d;
  logic             err_q, err_d;

  logic [2:0]       prev_inc;
  logic             legal_step;
  logic             wrap_step;
  logic             hold_step;
  logic [CNT_W-1:0] wrap_sat_inc;
  logic [CNT_W-1:0] errc_sat_inc;

  // Step classification of the incoming sample against the stored reference
  always_comb begin
    prev_inc     = prev_q + 3'd1;
    legal_step   = (cnt_in == prev_inc);
    wrap_step    = (prev_q == 3'd7) && (cnt_in == 3'd0);
`ifdef SEQ_MON_STALL_EN
    hold_step    = (cnt_in == prev_q);
`else
    hold_step    = 1'b0;
`endif
    wrap_sat_inc = (wrap_q == CNT_MAX) ? wrap_q : wrap_q + CNT_ONE;
    errc_sat_inc = (errc_q == CNT_MAX) ? errc_q : errc_q + CNT_ONE;
  end

  // Next-state: clr dominates, otherwise the FSM consumes one sample per strobe
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    onehot_d = onehot_q;
    wrap_d   = wrap_q;
    errc_d   = errc_q;
    err_d    = err_q;
    if (clr) begin
      state_d  = ST_IDLE;
      prev_d   = 3'd0;
      onehot_d = 8'h00;
      wrap_d   = '0;
      errc_d   = '0;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // First reference sample: accepted without any check
          if (cnt_vld) begin
            prev_d   = cnt_in;
            onehot_d = 8'h01 << cnt_in;
            state_d  = ST_TRACK;
          end
        end
        ST_TRACK, ST_FAULT: begin
          if (cnt_vld && !hold_step) begin
            prev_d   = cnt_in;
            onehot_d = 8'h01 << cnt_in;
            if (legal_step) begin
              if (wrap_step) begin
                wrap_d = wrap_sat_inc;
              end
              state_d = ST_TRACK;
            end else begin
              err_d   = 1'b1;
              errc_d  = errc_sat_inc;
              state_d = ST_FAULT;
            end
          end
        end
        default: begin
          // Unused encoding recovers to IDLE regardless of the strobe
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Status registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      prev_q   <= 3'd0;
      onehot_q <= 8'h00;
      wrap_q   <= '0;
      errc_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      onehot_q <= onehot_d;
      wrap_q   <= wrap_d;
      errc_q   <= errc_d;
      err_q    <= err_d;
    end
  end

  assign onehot_out = onehot_q;
  assign wrap_cnt   = wrap_q;
  assign err_cnt    = errc_q;
  assign err        = err_q;
  assign state_o    = state_q;

endmodule

// File: doc/seq_step_monitor.md
# seq_step_monitor

Downstream checker for the 3-bit free-running state counter. Samples the counter value on a strobe and verifies that each sample is the previous one plus 1 (mod 8). Produces a registered one-hot decode of the current count, a saturating wrap counter, a saturating error counter and a sticky error flag. Sits directly after the counter and feeds status and debug logic.

## Interface
- `CNT_W`, default 8: width of the `wrap_cnt` and `err_cnt` saturating counters.
- `clk`  in  1  system clock, rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `cnt_in`  in  3  counter value from the upstream stage.
- `cnt_vld`  in  1  sample strobe; `cnt_in` is sampled on a rising edge where this is 1.
- `clr`  in  1  synchronous clear of status; returns FSM to IDLE.
- `onehot_out`  out  8  registered one-hot decode of the last sampled `cnt_in`.
- `wrap_cnt`  out  CNT_W  count of legal 7→0 transitions; saturates at all-ones.
- `err_cnt`  out  CNT_W  count of illegal transitions; saturates at all-ones.
- `err`  out  1  sticky error flag.
- `state_o`  out  2  FSM state, for debug.

## Operation
- Internal register `prev[2:0]` holds the last sampled value.
- FSM encoding: IDLE=2'b00, TRACK=2'b01, FAULT=2'b10. Code 2'b11 is unused; if it is ever reached, the FSM goes to IDLE on the next edge.
- IDLE, on `cnt_vld`:
  - `prev <= cnt_in`
  - decode `cnt_in` into `onehot_out`
  - go to TRACK
  - No check is made; this is the first reference sample.
- TRACK, on `cnt_vld`:
  - Legal step (`cnt_in == prev+1` mod 8): update `prev` and `onehot_out`. If `prev==7` and `cnt_in==0`, increment `wrap_cnt`.
  - Illegal step: update `prev` and `onehot_out`, set `err`, increment `err_cnt`, go to FAULT.
- FAULT, on `cnt_vld`:
  - Always update `prev` and `onehot_out`.
  - Legal step: go to TRACK. `wrap_cnt` increments if this step is 7→0.
  - Illegal step: increment `err_cnt` and stay in FAULT.
- Without `cnt_vld`, all registers hold.
- Arithmetic:
  - `prev+1` is computed in 3 bits, so 7+1=0.
  - Counters saturate: an increment when the value is all-ones leaves it unchanged.
- `err` is sticky. Only `clr` or `rstn` clears it.
- `clr`:
  - Clears `wrap_cnt`, `err_cnt`, `err`, `onehot_out` and `prev`, and sets the FSM to IDLE.
  - `clr` wins over a simultaneous `cnt_vld`; that sample is discarded.

## Timing
- All outputs are registered. A sample taken at edge N is reflected in every output after edge N, so latency is one cycle from `cnt_vld` to output.
- Reset values (async assert, sync-to-clk deassert by the system):
  - `onehot_out=8'h00`
  - `wrap_cnt=0`, `err_cnt=0`, `err=0`
  - `state_o=IDLE`
  - `prev=0`
- Reset asserted mid-operation clears everything immediately. No pending sample survives.
- Back-to-back `cnt_vld` on every cycle is supported at full rate.
- The first sample after reset or `clr` never flags an error, whatever its value.

## Configuration
- `SEQ_MON_STALL_EN` defined:
  - A sample equal to `prev` is a legal hold. `onehot_out` and `prev` stay as they are, no counter changes, and the state is unchanged (TRACK stays TRACK, FAULT stays FAULT).
- `SEQ_MON_STALL_EN` not defined:
  - A repeated value is an illegal step and follows the illegal-step rules above.

## Test plan
- Reset, then `cnt_vld` held high with `cnt_in` stepping 0..7,0..7 (16 samples):
  - `err=0`, `err_cnt=0`, `wrap_cnt=1`.
  - `onehot_out` ends at 8'h80.
  - `state_o=TRACK`.
- Sequence 3,4,6,7,0:
  - `err` rises after the sample of 6, and `err_cnt=1`.
  - `state_o` is FAULT after the 6 and back to TRACK after the 7.
  - `wrap_cnt=1` after the 0.
  - `err` stays 1.
- Sequence 2,2 without the macro gives `err_cnt=1` and FAULT. With `SEQ_MON_STALL_EN`, 2,2,3 gives `err=0`, TRACK and `onehot_out=8'h08`.
- With `CNT_W=2`, 5 full wraps give `wrap_cnt=2'b11`, i.e. it saturates at 3.
- `clr` asserted on the same edge as a `cnt_vld` carrying an illegal value:
  - All counters are 0, `err=0`, `state_o=IDLE`.
  - The next sample of 5 gives `onehot_out=8'h20` and no error.
- `rstn` pulsed low mid-cycle while in FAULT: outputs go to reset values immediately, before the next edge.
